vector_exec_pipe: RTL and testbench
===================================

VECTOR_EXEC_PIPE -- requirements
Module: vector_exec_pipe

Interface
REQ-001 Parameter LANES, default 8, number of vector lanes (>=1).
REQ-002 Parameter LANE_W, default 16, bits per lane (>=4, power of two).
REQ-003 Parameter TAG_W, default 5, destination register tag width.
REQ-004 clk  input  1  rising-edge clock; the block uses one clock only.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  operation offered.
REQ-007 in_ready  output  1  operation accepted when high with in_valid.
REQ-008 in_op  input  vec_op_t (4)  operation code.
REQ-009 in_srcA, in_srcB  input  LANES*LANE_W  operands; lane i at bits [i*LANE_W +: LANE_W].
REQ-010 in_mask  input  LANES  per-lane enable.
REQ-011 in_tag  input  TAG_W  destination tag, carried through unchanged.
REQ-012 flush  input  1  discard all in-flight operations.
REQ-013 out_valid  output  1  result present.
REQ-014 out_ready  input  1  consumer takes the result.
REQ-015 out_result  output  LANES*LANE_W  lane results.
REQ-016 out_mask, out_sat  output  LANES  mask copy; per-lane saturation flag.
REQ-017 out_tag  output  TAG_W  tag of the presented result.
REQ-018 busy  output  1  any stage valid.

Function
REQ-019 Two stages: S1 latches operands, S2 holds the registered result; accept at edge N gives out_valid after edge N+1 when no stall occurs.
REQ-020 S2 loads when !s2_valid or out_ready; S1 advances into S2 on that condition; in_ready = !flush and (!s1_valid or S2 loads).
REQ-021 With out_ready held high, the block sustains one operation per cycle and issues no bubbles.
REQ-022 out_result, out_mask, out_sat and out_tag stay stable while out_valid and !out_ready.
REQ-023 ADD and SUB wrap modulo 2^LANE_W; ADDS and SUBS saturate to the signed max/min and set out_sat for that lane.
REQ-024 AND, OR and XOR are bitwise; SLL, SRL and SRA shift by srcB lane bits [log2(LANE_W)-1:0].
REQ-025 MUL returns the low LANE_W bits of the product; MIN and MAX are signed.
REQ-026 REDSUM puts the modulo-2^LANE_W sum of all unmasked srcA lanes in lane 0 and zero in the other lanes.
REQ-027 A masked-off lane returns its srcA lane unchanged with out_sat 0; an all-zero mask is legal.
REQ-028 An unused opcode returns an all-zero result, sets no sat flags, and completes normally.
REQ-029 When flush is high, s1_valid and s2_valid clear at the next edge; an in_valid in the same cycle is not accepted; flush takes priority over all other events.
REQ-030 busy = s1_valid | s2_valid.

Reset
REQ-031 Reset clears s1_valid and s2_valid and sets out_result, out_mask, out_sat and out_tag to 0 immediately; in_ready is 1 while flush is low.
REQ-032 Reset asserted mid-operation discards all in-flight operations; no partial output appears after deassertion.

Structure
REQ-033 Package vector_exec_pkg holds the vec_op_t enum (ADD=0, SUB, ADDS, SUBS, AND, OR, XOR, SLL, SRL, SRA, MUL, MIN, MAX, REDSUM=13).
REQ-034 Sub-module vector_lane_alu (one lane, combinational) is generated LANES times; the REDSUM adder tree lives in vector_exec_pipe.

Verification (LANES=4, LANE_W=8)
REQ-035 ADD srcA=0x7F_01_FF_10, srcB=0x01_01_01_F0, mask=1111 -> out_result 0x80_02_00_00 two cycles later, out_sat 0000.
REQ-036 ADDS with the same operands -> 0x7F_02_00_00, out_sat 1000; SUBS with lane 0x80-0x01 -> 0x80 and sat set.
REQ-037 REDSUM srcA=0x10_20_30_40, mask=0111 -> out_result 0x00_00_00_90.
REQ-038 10 back-to-back ops with out_ready=1 -> 10 results on consecutive cycles; then out_ready=0 for 3 cycles -> outputs frozen, in_ready drops after 2 more accepts.
REQ-039 flush with both stages full -> out_valid=0 and busy=0 the next cycle; the offered op is not accepted.
REQ-040 reset asserted while S2 is valid and stalled -> out_valid=0 immediately; after deassertion the first new op emerges with a clean tag.

Source files
------------

// File: rtl/vector_exec_pkg.sv
// Shared opcode definition for the vector execution pipe and its lane ALU.
package vector_exec_pkg;

   typedef enum logic [3:0] {
      ADD    = 4'd0,
      SUB    = 4'd1,
      ADDS   = 4'd2,
      SUBS   = 4'd3,
      AND    = 4'd4,
      OR     = 4'd5,
      XOR    = 4'd6,
      SLL    = 4'd7,
      SRL    = 4'd8,
      SRA    = 4'd9,
      MUL    = 4'd10,
      MIN    = 4'd11,
      MAX    = 4'd12,
      REDSUM = 4'd13
   } vec_op_t;

endpackage

// File: rtl/vector_exec_pipe_lane_alu.sv
// One combinational vector lane: element-wise arithmetic, logic, shift and signed compare.
// Zero latency, no flow control; REDSUM and unused opcodes yield zero here (the top merges the reduction).
module vector_lane_alu
   import vector_exec_pkg::*;
#(
   parameter int LANE_W = 16
) (
   input  vec_op_t           op,
   input  logic              en,
   input  logic [LANE_W-1:0] a,
   input  logic [LANE_W-1:0] b,
   output logic [LANE_W-1:0] res,
   output logic              sat
);

   localparam int SH_W = $clog2(LANE_W);
   localparam int MSB  = LANE_W - 1;
   localparam logic [LANE_W-1:0] SMAX = {1'b0, {(LANE_W-1){1'b1}}};
   localparam logic [LANE_W-1:0] SMIN = {1'b1, {(LANE_W-1){1'b0}}};

   logic [SH_W-1:0]     sh;
   logic [LANE_W-1:0]   sum;
   logic [LANE_W-1:0]   dif;
   logic [2*LANE_W-1:0] prod;
   logic                ovf_add;
   logic                ovf_sub;
   logic                lt;

   assign sh   = b[SH_W-1:0];
   assign sum  = a + b;
   assign dif  = a - b;
   assign prod = {{LANE_W{1'b0}}, a} * {{LANE_W{1'b0}}, b};
   assign lt   = $signed(a) < $signed(b);

   // Signed overflow: operands agree in sign (add) or differ (sub) and the result flips away from a.
   assign ovf_add = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
   assign ovf_sub = (a[MSB] != b[MSB]) && (dif[MSB] != a[MSB]);

   always_comb begin
      res = '0;
      sat = 1'b0;
      case (op)
         ADD:  res = sum;
         SUB:  res = dif;
         ADDS: begin
            res = ovf_add ? (a[MSB] ? SMIN : SMAX) : sum;
            sat = ovf_add;
         end
         SUBS: begin
            res = ovf_sub ? (a[MSB] ? SMIN : SMAX) : dif;
            sat = ovf_sub;
         end
         AND:  res = a & b;
         OR:   res = a | b;
         XOR:  res = a ^ b;
         SLL:  res = a << sh;
         SRL:  res = a >> sh;
         SRA:  res = $signed(a) >>> sh;
         MUL:  res = prod[LANE_W-1:0];
         MIN:  res = lt ? a : b;
         MAX:  res = lt ? b : a;
         default: res = '0;
      endcase
      // Masked lanes pass srcA through, but only for element-wise ops.
      if (!en && (op <= MAX)) begin
         res = a;
         sat = 1'b0;
      end
   end

endmodule

// File: rtl/vector_exec_pipe.sv
// Two-stage masked vector execution pipe: S1 holds operands, S2 holds the registered result (2-cycle latency).
// Valid/ready on both sides, full throughput when out_ready is high; flush and reset drop everything in flight.
module vector_exec_pipe
   import vector_exec_pkg::*;
#(
   parameter int LANES  = 8,
   parameter int LANE_W = 16,
   parameter int TAG_W  = 5
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  vec_op_t                 in_op,
   input  logic [LANES*LANE_W-1:0] in_srcA,
   input  logic [LANES*LANE_W-1:0] in_srcB,
   input  logic [LANES-1:0]        in_mask,
   input  logic [TAG_W-1:0]        in_tag,
   input  logic                    flush,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [LANES*LANE_W-1:0] out_result,
   output logic [LANES-1:0]        out_mask,
   output logic [LANES-1:0]        out_sat,
   output logic [TAG_W-1:0]        out_tag,
   output logic                    busy
);

   logic                    s1_valid;
   vec_op_t                 s1_op;
   logic [LANES*LANE_W-1:0] s1_a;
   logic [LANES*LANE_W-1:0] s1_b;
   logic [LANES-1:0]        s1_mask;
   logic [TAG_W-1:0]        s1_tag;
   logic                    s2_valid;
   logic                    s2_load;
   logic                    accept;
   logic [LANES*LANE_W-1:0] lane_res;
   logic [LANES-1:0]        lane_sat;
   logic [LANES*LANE_W-1:0] alu_res;
   logic [LANE_W-1:0]       red_sum;

   assign s2_load   = !s2_valid || out_ready;
   assign in_ready  = !flush && (!s1_valid || s2_load);
   assign accept    = in_valid && in_ready;
   assign out_valid = s2_valid;
   assign busy      = s1_valid | s2_valid;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      vector_lane_alu #(.LANE_W(LANE_W)) u_lane (
         .op  (s1_op),
         .en  (s1_mask[i]),
         .a   (s1_a[i*LANE_W +: LANE_W]),
         .b   (s1_b[i*LANE_W +: LANE_W]),
         .res (lane_res[i*LANE_W +: LANE_W]),
         .sat (lane_sat[i])
      );
   end

   // Written as a chain; synthesis balances it into a tree.
   always_comb begin
      red_sum = '0;
      for (int i = 0; i < LANES; i++) begin
         if (s1_mask[i]) red_sum = red_sum + s1_a[i*LANE_W +: LANE_W];
      end
      alu_res = lane_res;
      if (s1_op == REDSUM) alu_res[LANE_W-1:0] = red_sum;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_op    <= ADD;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_mask  <= '0;
         s1_tag   <= '0;
      end else if (flush) begin
         s1_valid <= 1'b0;
      end else if (accept) begin
         s1_valid <= 1'b1;
         s1_op    <= in_op;
         s1_a     <= in_srcA;
         s1_b     <= in_srcB;
         s1_mask  <= in_mask;
         s1_tag   <= in_tag;
      end else if (s2_load) begin
         s1_valid <= 1'b0;
      end
   end

   // Result registers only change when S2 is free or drained, so a stalled result stays put.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s2_valid   <= 1'b0;
         out_result <= '0;
         out_mask   <= '0;
         out_sat    <= '0;
         out_tag    <= '0;
      end else if (flush) begin
         s2_valid <= 1'b0;
      end else if (s2_load) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            out_result <= alu_res;
            out_mask   <= s1_mask;
            out_sat    <= lane_sat;
            out_tag    <= s1_tag;
         end
      end
   end

endmodule

// File: tb/tb_vector_exec_pipe.sv
// Self-checking bench for vector_exec_pipe (LANES=4, LANE_W=8): directed table, corner sequences, random scoreboard.
module tb_vector_exec_pipe;
   import vector_exec_pkg::*;

   localparam int L = 4;
   localparam int W = 8;
   localparam int T = 5;

   logic           clk = 1'b0;
   logic           reset;
   logic           in_valid;
   logic           in_ready;
   vec_op_t        in_op;
   logic [L*W-1:0] in_srcA;
   logic [L*W-1:0] in_srcB;
   logic [L-1:0]   in_mask;
   logic [T-1:0]   in_tag;
   logic           flush;
   logic           out_valid;
   logic           out_ready;
   logic [L*W-1:0] out_result;
   logic [L-1:0]   out_mask;
   logic [L-1:0]   out_sat;
   logic [T-1:0]   out_tag;
   logic           busy;

   vector_exec_pipe #(.LANES(L), .LANE_W(W), .TAG_W(T)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_srcA(in_srcA), .in_srcB(in_srcB), .in_mask(in_mask), .in_tag(in_tag), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_mask(out_mask),
      .out_sat(out_sat), .out_tag(out_tag), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  m;
      logic [31:0] r;
      logic [3:0]  s;
   } vec_t;

   typedef struct {
      logic [31:0] r;
      logic [3:0]  s;
      logic [3:0]  m;
      logic [4:0]  t;
   } exp_t;

   vec_t vt[13];
   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: per-lane integer arithmetic straight from the operation definitions.
   function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] m, output logic [31:0] r, output logic [3:0] s);
      int ua, ub, ai, bi, x, sum;
      r = '0; s = '0; sum = 0;
      for (int i = 0; i < 4; i++) begin
         ua = int'(a[i*8 +: 8]);
         ub = int'(b[i*8 +: 8]);
         ai = (ua >= 128) ? ua - 256 : ua;
         bi = (ub >= 128) ? ub - 256 : ub;
         x = 0;
         case (op)
            4'd0:  x = ua + ub;
            4'd1:  x = ua - ub;
            4'd2, 4'd3: begin
               x = (op == 4'd2) ? ai + bi : ai - bi;
               if (x > 127)       begin x = 127;  s[i] = 1'b1; end
               else if (x < -128) begin x = -128; s[i] = 1'b1; end
            end
            4'd4:  x = ua & ub;
            4'd5:  x = ua | ub;
            4'd6:  x = ua ^ ub;
            4'd7:  x = ua << (ub % 8);
            4'd8:  x = ua >> (ub % 8);
            4'd9:  x = ai >>> (ub % 8);
            4'd10: x = ua * ub;
            4'd11: x = (ai < bi) ? ai : bi;
            4'd12: x = (ai > bi) ? ai : bi;
            4'd13: if (m[i]) sum += ua;
            default: x = 0;
         endcase
         if (!m[i] && op <= 4'd12) begin x = ua; s[i] = 1'b0; end
         r[i*8 +: 8] = x[7:0];
      end
      if (op == 4'd13) r = {24'd0, sum[7:0]};
   endfunction

   task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] m, input logic [4:0] t);
      in_valid = 1'b1;
      in_op    = vec_op_t'(op);
      in_srcA  = a;
      in_srcB  = b;
      in_mask  = m;
      in_tag   = t;
   endtask

   function automatic exp_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [3:0] m, input logic [4:0] t);
      exp_t e;
      model(op, a, b, m, e.r, e.s);
      e.m = m;
      e.t = t;
      return e;
   endfunction

   initial begin
      exp_t e;
      exp_t hold[$];
      int   acc;
      logic [31:0] ra, rb;

      vt[0]  = '{4'd0,  32'h7F01FF10, 32'h010101F0, 4'hF, 32'h80020000, 4'b0000};
      vt[1]  = '{4'd2,  32'h7F01FF10, 32'h010101F0, 4'hF, 32'h7F020000, 4'b1000};
      vt[2]  = '{4'd3,  32'h80007F05, 32'h0101FF10, 4'hF, 32'h80FF7FF5, 4'b1010};
      vt[3]  = '{4'd13, 32'h10203040, 32'hDEADBEEF, 4'h7, 32'h00000090, 4'b0000};
      vt[4]  = '{4'd9,  32'h80F04001, 32'h07040109, 4'hF, 32'hFFFF2000, 4'b0000};
      vt[5]  = '{4'd8,  32'h80F04001, 32'h07040109, 4'hF, 32'h010F2000, 4'b0000};
      vt[6]  = '{4'd10, 32'h10FF0380, 32'h10FF0502, 4'hF, 32'h00010F00, 4'b0000};
      vt[7]  = '{4'd11, 32'h807F05FE, 32'h7F800601, 4'hF, 32'h808005FE, 4'b0000};
      vt[8]  = '{4'd12, 32'h807F05FE, 32'h7F800601, 4'hF, 32'h7F7F0601, 4'b0000};
      vt[9]  = '{4'd0,  32'h11223344, 32'h01010101, 4'h5, 32'h11233345, 4'b0000};
      vt[10] = '{4'd2,  32'h7F7F7F7F, 32'h01010101, 4'h0, 32'h7F7F7F7F, 4'b0000};
      vt[11] = '{4'd14, 32'h12345678, 32'h11111111, 4'hF, 32'h00000000, 4'b0000};
      vt[12] = '{4'd1,  32'h00108005, 32'h01200105, 4'hF, 32'hFFF07F00, 4'b0000};

      reset = 1'b1; in_valid = 1'b0; in_op = ADD; in_srcA = '0; in_srcB = '0;
      in_mask = '0; in_tag = '0; flush = 1'b0; out_ready = 1'b1;
      #12;
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_result", out_result, 0);
      check("rst_sat_tag", {out_sat, out_mask, out_tag}, 0);
      check("rst_in_ready", in_ready, 1);
      @(negedge clk) reset = 1'b0;

      // Directed table: one op at a time, checking latency and every output field.
      for (int i = 0; i < 13; i++) begin
         @(negedge clk) drive(vt[i].op, vt[i].a, vt[i].b, vt[i].m, 5'(i));
         @(negedge clk) in_valid = 1'b0;
         check($sformatf("vec%0d_early", i), out_valid, 0);
         @(negedge clk);
         check($sformatf("vec%0d_valid", i), out_valid, 1);
         check($sformatf("vec%0d_result", i), out_result, vt[i].r);
         check($sformatf("vec%0d_sat", i), out_sat, vt[i].s);
         check($sformatf("vec%0d_mask_tag", i), {out_mask, out_tag}, {vt[i].m, 5'(i)});
      end
      @(negedge clk);

      // Ten back-to-back ops with out_ready high: results on ten consecutive cycles.
      hold.delete();
      for (int c = 0; c < 13; c++) begin
         @(negedge clk);
         if (c < 10) begin
            ra = $urandom; rb = $urandom;
            drive(4'd0, ra, rb, 4'hF, 5'(c));
            hold.push_back(mk(4'd0, ra, rb, 4'hF, 5'(c)));
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (c < 10) check("b2b_in_ready", in_ready, 1);
         if (c >= 2 && c < 12) begin
            e = hold.pop_front();
            check("b2b_valid", out_valid, 1);
            check("b2b_tag", out_tag, e.t);
            check("b2b_result", out_result, e.r);
         end
         if (c == 12) check("b2b_drained", out_valid, 0);
      end

      // Stall: out_ready low on an empty pipe takes exactly two ops, then the head result holds.
      out_ready = 1'b0;
      acc = 0;
      hold.delete();
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         ra = 32'h01020304 * (acc + 1); rb = 32'h10203040;
         drive(4'd2, ra, rb, 4'hF, 5'(20 + acc));
         #1;
         if (in_ready) begin
            hold.push_back(mk(4'd2, ra, rb, 4'hF, 5'(20 + acc)));
            acc++;
         end
         if (c >= 2) begin
            check("stall_in_ready", in_ready, 0);
            check("stall_valid", out_valid, 1);
            check("stall_frozen", {out_result, out_sat, out_tag}, {hold[0].r, hold[0].s, hold[0].t});
         end
      end
      check("stall_accepts", acc, 2);

      // Flush with both stages full: nothing survives and the offered op is refused.
      @(negedge clk);
      flush = 1'b1;
      drive(4'd0, 32'h0, 32'h0, 4'hF, 5'd30);
      #1 check("flush_in_ready", in_ready, 0);
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      check("flush_valid", out_valid, 0);
      check("flush_busy", busy, 0);
      out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("flush_no_ghost", out_valid, 0);

      // Reset while S2 is valid and stalled, then a fresh op emerges cleanly.
      out_ready = 1'b0;
      @(negedge clk) drive(4'd6, 32'hAAAAAAAA, 32'h55555555, 4'hF, 5'd7);
      @(negedge clk) in_valid = 1'b0;
      @(negedge clk) check("rst_mid_pre", out_valid, 1);
      #2 reset = 1'b1;
      #1;
      check("rst_mid_valid", out_valid, 0);
      check("rst_mid_tag_busy", {out_tag, busy}, 0);
      @(negedge clk) reset = 1'b0;
      out_ready = 1'b1;
      @(negedge clk) drive(4'd5, 32'h0F0F0000, 32'hF0000F0F, 4'hF, 5'd9);
      @(negedge clk) in_valid = 1'b0;
      check("rst_mid_no_old", out_valid, 0);
      @(negedge clk);
      check("rst_mid_new", {out_valid, out_tag}, {1'b1, 5'd9});
      check("rst_mid_new_res", out_result, 32'hFF0F0F0F);
      @(negedge clk);

      // Randomized traffic against the scoreboard.
      q.delete();
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         ra = $urandom; rb = $urandom;
         in_valid  = ($urandom_range(0, 9) < 7);
         in_op     = vec_op_t'(4'($urandom_range(0, 15)));
         in_srcA   = ra;
         in_srcB   = rb;
         in_mask   = 4'($urandom);
         in_tag    = 5'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 39) == 0);
         if (c >= 2980) begin in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0; end
         #1;
         check("rnd_busy", busy, (q.size() != 0));
         check("rnd_in_ready", in_ready, !flush && (q.size() < 2 || out_ready));
         if (flush) begin
            q.delete();
         end else begin
            if (out_valid && out_ready) begin
               if (q.size() == 0) begin
                  check("rnd_spurious_out", out_valid, 0);
               end else begin
                  e = q.pop_front();
                  check("rnd_result", out_result, e.r);
                  check("rnd_sat_mask_tag", {out_sat, out_mask, out_tag}, {e.s, e.m, e.t});
               end
            end
            if (in_valid && in_ready) q.push_back(mk(4'(in_op), ra, rb, in_mask, in_tag));
         end
      end
      check("rnd_drain", q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
